// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 command transmitter.
//
// Sends one byte to the device on the shared ps2clk/ps2data pair:
// request-to-send (clock inhibit, then start bit), data LSB first, odd
// parity and stop bit, each driven after a device falling clock edge.
// The device acknowledge is checked at the end of the frame.
//
// Optional feature: define PS2_TX_TIMEOUT_EN to enable a watchdog that
// aborts a frame TIMEOUT_CYCLES after acceptance if the device stalls.
//
// Ports:
//   clock       system clock (25 MHz)
//   reset       asynchronous active-low reset
//   ps2clk      PS/2 clock pin level (asynchronous)
//   ps2data     PS/2 data pin level (asynchronous)
//   tx_data     byte to send, latched on acceptance
//   tx_valid    send request, accepted when tx_ready=1
//   tx_ready    high only while idle
//   tx_done     one-cycle pulse: frame sent and ACK seen
//   tx_err      one-cycle pulse: NACK or watchdog timeout
//   ps2clk_oe   1 = pull ps2clk low (open collector)
//   ps2data_oe  1 = pull ps2data low (open collector)
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 3000,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       ps2clk_oe,
  output logic       ps2data_oe
);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_REL} state_t;

  localparam logic [11:0] INH_LAST = 12'(INHIBIT_CYCLES - 1);
  localparam logic [18:0] WD_LAST  = 19'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  clk_hist;
  logic [1:0]  data_sync;
  logic [9:0]  frame;     // {stop, parity, d7..d0}
  logic [11:0] inh_cnt;
  logic [3:0]  bit_cnt;
  logic        ack_ok;
  logic        fall_edge;
  logic        data_s;

  // History doubles as the clock synchronizer; requiring four stable highs
  // then four stable lows rejects glitches on the slow device clock.
  assign fall_edge = (clk_hist[7:4] == 4'hF) && (clk_hist[3:0] == 4'h0);
  assign data_s    = data_sync[1];

`ifdef PS2_TX_TIMEOUT_EN
  logic [18:0] wdog;
  logic        wd_hit;
  // Only the device-paced states can stall; inhibit/request are self-timed.
  assign wd_hit = (wdog >= WD_LAST) &&
                  (state == SHIFT || state == ACK || state == WAIT_REL);
`else
  // Keeps the timeout parameter referenced when the watchdog is compiled out.
  logic unused_wd_cfg;
  assign unused_wd_cfg = ^WD_LAST;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_hist  <= 8'hFF;
      data_sync <= 2'b11;
    end else begin
      clk_hist  <= {clk_hist[6:0], ps2clk};
      data_sync <= {data_sync[0], ps2data};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      tx_ready   <= 1'b1;
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
      ps2clk_oe  <= 1'b0;
      ps2data_oe <= 1'b0;
      frame      <= '0;
      inh_cnt    <= '0;
      bit_cnt    <= '0;
      ack_ok     <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wdog       <= '0;
`endif
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      if (state != IDLE) wdog <= wdog + 19'd1;
      if (wd_hit) begin
        state      <= IDLE;
        ps2clk_oe  <= 1'b0;
        ps2data_oe <= 1'b0;
        tx_err     <= 1'b1;
      end else
`endif
      begin
        case (state)
          IDLE: begin
            ps2clk_oe  <= 1'b0;
            ps2data_oe <= 1'b0;
            // tx_ready is registered so it reappears one cycle after a
            // done/err pulse rather than alongside it.
            if (tx_ready && tx_valid) begin
              frame     <= {1'b1, ~^tx_data, tx_data};
              inh_cnt   <= '0;
              bit_cnt   <= '0;
              ack_ok    <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
              wdog      <= '0;
`endif
              tx_ready  <= 1'b0;
              ps2clk_oe <= 1'b1;
              state     <= INHIBIT;
            end else begin
              tx_ready <= 1'b1;
            end
          end
          INHIBIT: begin
            if (inh_cnt == INH_LAST) begin
              ps2data_oe <= 1'b1;  // start bit
              state      <= REQ;
            end else begin
              inh_cnt <= inh_cnt + 12'd1;
            end
          end
          REQ: begin
            ps2clk_oe <= 1'b0;
            bit_cnt   <= '0;
            state     <= SHIFT;
          end
          SHIFT: begin
            if (fall_edge) begin
              ps2data_oe <= ~frame[bit_cnt];
              bit_cnt    <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd9) state <= ACK;
            end
          end
          ACK: begin
            if (fall_edge) begin
              ack_ok <= ~data_s;
              state  <= WAIT_REL;
            end
          end
          WAIT_REL: begin
            if (data_s && clk_hist == 8'hFF) begin
              tx_done <= ack_ok;
              tx_err  <= ~ack_ok;
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model clocks frames out of
// the host, and a scoreboard queue holds the expected line bits and frame
// outcome pushed when each request is issued.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH = 50;
  localparam int TMO = 2000;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err, ps2clk_oe, ps2data_oe;
  wire        ps2clk  = dev_clk  & ~ps2clk_oe;
  wire        ps2data = dev_data & ~ps2data_oe;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;
  logic       exp_bits[$];
  logic [1:0] exp_res[$];   // {done, err}

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .ps2clk(ps2clk), .ps2data(ps2data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_err(tx_err), .ps2clk_oe(ps2clk_oe),
    .ps2data_oe(ps2data_oe)
  );

  always #20 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send(input logic [7:0] d, input bit inject);
    int n;
    n = 0;
    while (!tx_ready && n < 1000) begin tick(1); n++; end
    chk("ready_before_send", int'(tx_ready), 1);
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    exp_bits.push_back(($countones(d) % 2 == 0) ? 1'b1 : 1'b0);
    exp_bits.push_back(1'b1);
    tick(1);
    tx_valid = 1'b0;
    tx_data  = 8'hA5;  // must not affect the latched byte
    acc_cyc  = cyc;
    chk("accept_ready_low", int'(tx_ready), 0);
    chk("accept_clk_oe", int'(ps2clk_oe), 1);
    chk("accept_data_oe", int'(ps2data_oe), 0);
    n = 0;
    while (!ps2data_oe && n < INH + 100) begin
      if (inject && n == 5) begin tx_valid = 1'b1; tx_data = 8'h55; end
      if (inject && n == 6) tx_valid = 1'b0;
      tick(1);
      n++;
    end
    tx_valid = 1'b0;
    chk("inhibit_len", n, INH);
    chk("req_clk_held", int'(ps2clk_oe), 1);
    tick(1);
    chk("req_clk_release", int'(ps2clk_oe), 0);
    chk("start_bit_held", int'(ps2data_oe), 1);
  endtask

  // Device clocks nedges falling edges; edges 1..10 carry frame bits sampled
  // while the clock is low, edge 11 is the acknowledge edge.
  task automatic dev_clock(input int nedges, input bit ack);
    logic b;
    tick(30);
    for (int e = 1; e <= nedges; e++) begin
      if (e == 11) dev_data = ack ? 1'b0 : 1'b1;
      dev_clk = 1'b0;
      tick(20);
      if (e <= 10) begin
        chk("bit_queue_nonempty", int'(exp_bits.size() != 0), 1);
        if (exp_bits.size() != 0) begin
          b = exp_bits.pop_front();
          chk($sformatf("line_bit%0d", e), int'(ps2data), int'(b));
        end
      end
      dev_clk = 1'b1;
      if (e == 11) dev_data = 1'b1;
      else tick(20);
    end
  endtask

  task automatic wait_result();
    int n;
    logic [1:0] r;
    n = 0;
    while (!(tx_done || tx_err) && n < 2000) begin tick(1); n++; end
    r = (exp_res.size() != 0) ? exp_res.pop_front() : 2'b11;
    chk("result", int'({tx_done, tx_err}), int'(r));
    tick(1);
    chk("pulse_one_cycle", int'({tx_done, tx_err}), 0);
    chk("ready_after_pulse", int'(tx_ready), 1);
    chk("lines_released", int'({ps2clk_oe, ps2data_oe}), 0);
  endtask

  task automatic frame_ok(input logic [7:0] d, input bit inject);
    exp_res.push_back(2'b10);
    send(d, inject);
    dev_clock(11, 1'b1);
    wait_result();
  endtask

  initial begin
    int n;
    tick(3);
    chk("rst_ready", int'(tx_ready), 1);
    chk("rst_oe", int'({ps2clk_oe, ps2data_oe}), 0);
    chk("rst_pulses", int'({tx_done, tx_err}), 0);
    reset = 1'b1;
    tick(2);

    frame_ok(8'hED, 1'b0);   // line 1,0,1,1,0,1,1,1 parity 1 stop 1
    frame_ok(8'hF4, 1'b0);   // parity 0
    frame_ok(8'h00, 1'b0);   // parity 1

    // NACK: device leaves data high on the ack edge
    exp_res.push_back(2'b01);
    send(8'h3A, 1'b0);
    dev_clock(11, 1'b0);
    wait_result();

    // request during inhibit is ignored, original byte goes out
    frame_ok(8'hA7, 1'b1);

    // reset while the device holds clock low on edge 5 (bit 4 on the line)
    send(8'h3C, 1'b0);
    dev_clock(4, 1'b1);
    dev_clk = 1'b0;
    tick(8);
    #5 reset = 1'b0;
    #1;
    chk("midrst_oe", int'({ps2clk_oe, ps2data_oe}), 0);
    chk("midrst_ready", int'(tx_ready), 1);
    tick(2);
    reset = 1'b1;
    dev_clk = 1'b1;
    exp_bits.delete();
    tick(10);
    frame_ok(8'hFF, 1'b0);

    // device stalls after five edges
    send(8'h81, 1'b0);
    dev_clock(5, 1'b1);
    exp_bits.delete();
`ifdef PS2_TX_TIMEOUT_EN
    n = 0;
    while (!tx_err && n < TMO + 200) begin tick(1); n++; end
    chk("timeout_err", int'(tx_err), 1);
    chk("timeout_latency", cyc - acc_cyc, TMO);
    chk("timeout_done_low", int'(tx_done), 0);
    chk("timeout_release", int'({ps2clk_oe, ps2data_oe}), 0);
    tick(1);
    chk("timeout_ready", int'(tx_ready), 1);
`else
    n = 0;
    while (!tx_err && n < TMO + 200) begin tick(1); n++; end
    chk("stall_no_err", int'(tx_err), 0);
    chk("stall_ready_low", int'(tx_ready), 0);
    chk("stall_clk_released", int'(ps2clk_oe), 0);
    chk("stall_bit4_held", int'(ps2data_oe), 1);  // d4 of 0x81 is 0
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(2);
`endif
    frame_ok(8'h5A, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (LED set 0xED, reset 0xFF, enable 0xF4, ...) to the keyboard over the same ps2clk/ps2data pair the keyboard receiver listens on. Performs the request-to-send sequence, shifts out data, odd parity and stop bit on device-generated clock edges, then checks the device acknowledge. Sits beside the keyboard receiver on the 25 MHz domain; its open-collector enables drive the pad tri-states in the top level.

## Interface
- INHIBIT_CYCLES, 3000: cycles ps2clk is held low for request-to-send (120 µs at 25 MHz).
- TIMEOUT_CYCLES, 500000: watchdog limit in cycles (20 ms at 25 MHz), see Configuration.
- clock  in  1  system clock (25 MHz).
- reset  in  1  asynchronous, active-low reset.
- ps2clk  in  1  PS/2 clock pin level (asynchronous).
- ps2data  in  1  PS/2 data pin level (asynchronous).
- tx_data  in  8  byte to send, sampled when accepted.
- tx_valid  in  1  request; accepted on a rising clock edge where tx_ready=1.
- tx_ready  out  1  high only in IDLE.
- tx_done  out  1  one-cycle pulse: byte sent and ACK received.
- tx_err  out  1  one-cycle pulse: NACK or timeout.
- ps2clk_oe  out  1  1 = pull ps2clk low; 0 = release.
- ps2data_oe  out  1  1 = pull ps2data low; 0 = release.

## Operation
- Falling-edge detect on ps2clk: 8-bit history shifted every clock; fall_edge = history[7:4]==4'hF && history[3:0]==4'h0. ps2data passes through a 2-flop synchronizer.
- Frame = {stop=1, parity, d7..d0}, LSB first; parity = ~^tx_data (odd parity over data+parity).
- States:
  - IDLE: both oe=0, tx_ready=1. tx_valid -> latch tx_data, clear counters, go INHIBIT.
  - INHIBIT: ps2clk_oe=1, ps2data_oe=0; counts INHIBIT_CYCLES then sets ps2data_oe=1 (start bit) and goes REQ.
  - REQ: ps2clk_oe=1, ps2data_oe=1 for one cycle, then ps2clk_oe=0; go SHIFT, bit counter=0.
  - SHIFT: on each fall_edge drive bit[cnt] (ps2data_oe = ~bit), cnt++. Edges 1-8: d0..d7; edge 9: parity; edge 10: stop (ps2data_oe=0). After edge 10 go ACK.
  - ACK: on next fall_edge sample synced ps2data: 0 -> WAIT_REL with ack_ok=1; 1 -> WAIT_REL with ack_ok=0.
  - WAIT_REL: wait until synced ps2data=1 and ps2clk history==8'hFF; pulse tx_done (ack_ok) or tx_err (!ack_ok); go IDLE.
- tx_valid outside IDLE is ignored; no queueing.
- The receiver may see the frame echo as garbage; it rejects it via its own parity/start checks.

## Timing
- Reset (reset=0, asynchronous): state IDLE, tx_ready=1, tx_done=0, tx_err=0, ps2clk_oe=0, ps2data_oe=0, history=8'hFF, counters 0. Reset mid-frame releases both lines immediately.
- Accept at edge T: tx_ready=0 and ps2clk_oe=1 from T+1.
- ps2data_oe rises exactly INHIBIT_CYCLES cycles after ps2clk_oe rises; ps2clk_oe falls one cycle later.
- Data output updates the cycle after fall_edge asserts (fall_edge itself lags the pin by 4-5 cycles).
- tx_done/tx_err high exactly one cycle; tx_ready returns to 1 the cycle after the pulse. Next tx_valid may be accepted that same cycle.
- Counters: inhibit counter 12 bits, bit counter 4 bits, watchdog 19 bits; no wrap within a frame.

## Configuration
- PS2_TX_TIMEOUT_EN defined: watchdog starts on leaving IDLE, counts every cycle; reaching TIMEOUT_CYCLES in SHIFT, ACK or WAIT_REL releases both lines, pulses tx_err, returns IDLE.
- Not defined: no watchdog logic; block waits indefinitely for device edges (only reset recovers).

## Test plan
- tx_data=0xED, device model clocks 11 edges and ACKs -> bits on line 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done pulses once; tx_err stays 0.
- tx_data=0xF4 -> parity 0 on edge 9; tx_data=0x00 -> parity 1; both complete with tx_done.
- Device leaves data high on ACK edge -> tx_err pulses once, tx_done stays 0, back to IDLE with both oe=0.
- PS2_TX_TIMEOUT_EN, device stops after 5 edges -> tx_err at TIMEOUT_CYCLES after accept, lines released; without macro, block stays in SHIFT.
- reset asserted during SHIFT bit 4 -> ps2clk_oe=ps2data_oe=0 immediately, tx_ready=1; new 0xFF after release completes normally.
- tx_valid pulsed during INHIBIT with 0x55 -> ignored; original byte transmitted unchanged.
